button_event_ctrl: RTL and testbench
====================================

// Module: button_event_ctrl
// PURPOSE
// - Multi-channel button front end; generalises the single-button start-on-release detector.
// - Per channel: optional 2-FF synchroniser, counter debouncer, press/release/long-press FSM.
// - Outputs are one-cycle pulses for game/control FSMs: press, start (short-press release), long_press.
// - Also outputs a held level per channel.
// - Sits between raw board buttons and the top-level control logic.
// PARAMETERS
// - CHANNELS         4     number of independent button channels (>=1)
// - DEBOUNCE_CYCLES  16    consecutive cycles a new level must persist before acceptance (>=1)
// - LONG_CYCLES      1000  cycles from press pulse to long_press pulse (>=2)
// PORTS
// - clk         in   1         system clock, all state on rising edge
// - rst_n       in   1         asynchronous, active-low reset
// - enable      in   1         1 = FSMs advance and may pulse; 0 = FSMs frozen
// - btn         in   CHANNELS  raw button levels, 1 = pressed, asynchronous to clk
// - press       out  CHANNELS  1-cycle pulse on accepted press
// - start       out  CHANNELS  1-cycle pulse on release of a short press
// - long_press  out  CHANNELS  1-cycle pulse when hold reaches LONG_CYCLES
// - held        out  CHANNELS  level, 1 while FSM in PRESSED or LONG
// BEHAVIOUR
// - Reset: all outputs 0; synchroniser FFs 0, debounced level db 0, counters 0, FSM IDLE.
// - Reset acts immediately and asynchronously, including mid-press; no pulse is emitted because of reset.
// - Channels are fully independent; identical logic replicated CHANNELS times.
// - Debounce counter:
//   - Width $clog2(DEBOUNCE_CYCLES+1).
//   - Increments on each edge where btn_s != db.
//   - Clears on any edge where btn_s == db.
//   - On the edge where cnt == DEBOUNCE_CYCLES-1 and btn_s != db: db <= btn_s and cnt <= 0.
//   - Runs regardless of enable.
// - FSM states IDLE, PRESSED, LONG; transitions only on edges with enable=1.
//   - IDLE -> PRESSED when db=1; press pulses; hold_cnt <= 0.
//   - PRESSED -> IDLE when db=0; start pulses.
//   - PRESSED -> LONG when db=1 and hold_cnt == LONG_CYCLES-1; long_press pulses.
//   - Otherwise in PRESSED, hold_cnt increments.
//   - LONG -> IDLE when db=0; no pulse (long press consumes the release).
// - hold_cnt: width $clog2(LONG_CYCLES); never wraps (leaves PRESSED at threshold).
// - Pulses are registered and high for exactly one cycle, in the cycle after the transition edge.
// - press/start/long_press are never asserted together on one channel.
// - Latency: edge 0 = first clk edge sampling the new btn level.
//   - db updates at edge DEBOUNCE_CYCLES+1 (with synchroniser) / DEBOUNCE_CYCLES-1 (without).
//   - Pulse is visible after edge DEBOUNCE_CYCLES+2 / DEBOUNCE_CYCLES.
// - long_press rises exactly LONG_CYCLES cycles after press rose, if enable stays 1.
// - enable=0: state and hold_cnt frozen; pulses 0; held keeps its value.
// - enable rising while db=1 in IDLE: press on the next edge.
// - Bounce shorter than DEBOUNCE_CYCLES: no effect on db or outputs.
// CONFIGURATION
// - Macro BUTTON_SYNC_EN:
//   - Defined: 2-FF synchroniser per channel; btn_s = btn delayed 2 cycles.
//   - Undefined: btn_s = btn directly; 2 cycles less latency. Only for btn already synchronous to clk.
// TESTING (bench: CHANNELS=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=32, BUTTON_SYNC_EN defined, enable=1)
// - btn[0] high 20 cycles, then low:
//   - press[0] after edge 6; held[0]=1.
//   - start[0] after edge 6 counted from the release; no long_press[0].
// - btn[1] high 3 cycles, then low -> no pulses and held[1]=0 throughout.
// - btn[0] high 60 cycles:
//   - long_press[0] exactly 32 cycles after press[0].
//   - On release, held[0] falls; no start[0].
// - enable=0, btn[0] high 20 cycles -> no pulses.
//   - Then enable=1 with btn still high -> press[0] on the next edge.
// - rst_n low mid-hold (held[0]=1) -> all outputs 0 asynchronously.
//   - After rst_n high with btn released: no start[0].
// - BUTTON_SYNC_EN undefined, btn[0] rises -> press[0] after edge 4 (2 earlier than synced).

Source files
------------

// File: rtl/button_event_ctrl.sv
// Multi-channel button front end: optional 2-FF synchroniser, counter debouncer
// and a press / short-release / long-press event FSM per channel.
// Optional feature macro: BUTTON_SYNC_EN (defined = 2-FF synchroniser per channel;
// undefined = btn is used directly and must already be synchronous to clk).
module button_event_ctrl #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] start,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] held
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic              btn_s;
    logic              db_q;
    logic [CNT_W-1:0]  cnt_q;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              start_q, start_d;
    logic              long_q, long_d;
    logic              held_q, held_d;

`ifdef BUTTON_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser for the asynchronous raw button level
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], btn[i]};
    end

    assign btn_s = sync_q[1];
`else
    assign btn_s = btn[i];
`endif

    // Debouncer: a new level is accepted after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_q  <= 1'b0;
        cnt_q <= '0;
      end else if (btn_s != db_q) begin
        if (cnt_q == CNT_LAST) begin
          db_q  <= btn_s;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end

    // Event FSM next state and next outputs; frozen while enable is low
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      press_d = 1'b0;
      start_d = 1'b0;
      long_d  = 1'b0;
      if (enable) begin
        case (state_q)
          S_IDLE: begin
            if (db_q) begin
              state_d = S_PRESSED;
              hold_d  = '0;
              press_d = 1'b1;
            end
          end
          S_PRESSED: begin
            if (!db_q) begin
              state_d = S_IDLE;
              start_d = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
              state_d = S_LONG;
              long_d  = 1'b1;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
          S_LONG: begin
            // Release after a long press is swallowed
            if (!db_q) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      held_d = (state_d != S_IDLE);
    end

    // FSM state and registered pulse/level outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        hold_q  <= '0;
        press_q <= 1'b0;
        start_q <= 1'b0;
        long_q  <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        press_q <= press_d;
        start_q <= start_d;
        long_q  <= long_d;
        held_q  <= held_d;
      end
    end

    assign press[i]      = press_q;
    assign start[i]      = start_q;
    assign long_press[i] = long_q;
    assign held[i]       = held_q;
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: scripted scenarios with literal
// latency expectations plus randomized stimulus against an event-level model.
module tb_button_event_ctrl;

  localparam int CH = 2;
  localparam int D  = 4;
  localparam int L  = 32;
`ifdef BUTTON_SYNC_EN
  localparam int SYNC = 2;
  localparam int LAT  = 6;
`else
  localparam int SYNC = 0;
  localparam int LAT  = 4;
`endif

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [CH-1:0] btn;
  logic [CH-1:0] press, start, long_press, held;

  int checks = 0;
  int errors = 0;

  button_event_ctrl #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .btn(btn),
    .press(press), .start(start), .long_press(long_press), .held(held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: delayed samples, accepted level, run length of disagreeing samples,
  // and an event view of the button (down / long-reached / enabled edges since press)
  bit m_p1[CH], m_p2[CH], m_db[CH], m_down[CH], m_long[CH];
  int m_run[CH], m_age[CH];
  bit e_press[CH], e_start[CH], e_long[CH], e_held[CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_p1[c] = 0; m_p2[c] = 0; m_db[c] = 0; m_down[c] = 0; m_long[c] = 0;
      m_run[c] = 0; m_age[c] = 0;
      e_press[c] = 0; e_start[c] = 0; e_long[c] = 0; e_held[c] = 0;
    end
  endtask

  // One rising edge of behaviour, evaluated on the inputs present at that edge
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit s, db_old;
      s = (SYNC == 2) ? m_p2[c] : btn[c];
      m_p2[c] = m_p1[c];
      m_p1[c] = btn[c];
      db_old = m_db[c];
      if (s != m_db[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_db[c]  = s;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      e_press[c] = 0; e_start[c] = 0; e_long[c] = 0;
      if (enable) begin
        if (!m_down[c]) begin
          if (db_old) begin
            m_down[c] = 1; m_age[c] = 0; e_press[c] = 1;
          end
        end else if (!db_old) begin
          if (!m_long[c]) e_start[c] = 1;
          m_down[c] = 0; m_long[c] = 0;
        end else if (!m_long[c]) begin
          m_age[c]++;
          if (m_age[c] == L) begin
            m_long[c] = 1; e_long[c] = 1;
          end
        end
      end
      e_held[c] = m_down[c];
    end
  endtask

  // Advance one clock, update the model, compare all outputs mid-cycle
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("press[%0d]", c), 32'(press[c]), 32'(e_press[c]));
      check($sformatf("start[%0d]", c), 32'(start[c]), 32'(e_start[c]));
      check($sformatf("long_press[%0d]", c), 32'(long_press[c]), 32'(e_long[c]));
      check($sformatf("held[%0d]", c), 32'(held[c]), 32'(e_held[c]));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  int p_at, s_at, l_at, flag;
  int rem[CH];

  initial begin
    rst_n = 1'b0; enable = 1'b1; btn = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({press, start, long_press, held}), 32'd0);
    rst_n = 1'b1;
    idle_cycles(4);

    // Short press on channel 0
    btn[0] = 1'b1; p_at = -1; s_at = -1; flag = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (press[0] && p_at < 0) p_at = k;
    end
    check("short_press_latency", 32'(p_at), 32'(LAT));
    check("short_held", 32'(held[0]), 32'd1);
    btn[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (start[0] && s_at < 0) s_at = k;
      if (long_press[0]) flag = 1;
    end
    check("start_latency", 32'(s_at), 32'(LAT));
    check("short_no_long", 32'(flag), 32'd0);

    // Bounce shorter than the debounce window on channel 1
    flag = 0;
    btn[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (press[1] | start[1] | long_press[1] | held[1]) flag = 1;
    end
    btn[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (press[1] | start[1] | long_press[1] | held[1]) flag = 1;
    end
    check("bounce_ignored", 32'(flag), 32'd0);

    // Long press on channel 0
    btn[0] = 1'b1; p_at = -1; l_at = -1; flag = 0;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (press[0] && p_at < 0) p_at = k;
      if (long_press[0] && l_at < 0) l_at = k;
    end
    check("long_press_seen", 32'(l_at >= 0), 32'd1);
    check("long_after_press", 32'(l_at - p_at), 32'(L));
    btn[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (start[0]) flag = 1;
    end
    check("long_no_start", 32'(flag), 32'd0);
    check("long_held_fall", 32'(held[0]), 32'd0);

    // Disabled press, then enable with the button still down
    enable = 1'b0; btn[0] = 1'b1; flag = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (press[0] | start[0] | long_press[0]) flag = 1;
    end
    check("disabled_no_pulse", 32'(flag), 32'd0);
    enable = 1'b1;
    cycle();
    check("enable_press_next_edge", 32'(press[0]), 32'd1);
    btn[0] = 1'b0;
    idle_cycles(20);

    // Asynchronous reset in the middle of a hold
    btn[0] = 1'b1;
    idle_cycles(15);
    check("pre_reset_held", 32'(held[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({press, start, long_press, held}), 32'd0);
    btn[0] = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    flag = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (start[0]) flag = 1;
    end
    check("post_reset_no_start", 32'(flag), 32'd0);

    // Randomized levels, hold times and enable, checked against the model
    for (int c = 0; c < CH; c++) rem[c] = $urandom_range(1, 60);
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < CH; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          btn[c] = ~btn[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(1, 60);
        end
      end
      enable = ($urandom_range(0, 15) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
